// File: rtl/switch_event_arbiter_pkg.sv
// Shared definitions for the switch event arbiter: FSM encoding and default sizing.
package switch_event_arbiter_pkg;

  localparam int unsigned C_NUM_SW_DEF     = 4;
  localparam int unsigned C_LONG_LIMIT_DEF = 25000000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single-switch build.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_event_arbiter_track.sv
// Per-switch tracker: press-edge and long-hold detection with pending bits and a sticky loss flag.
module switch_event_track
  import switch_event_arbiter_pkg::*;
#(
  parameter  int unsigned c_LONG_LIMIT = C_LONG_LIMIT_DEF,
  localparam int unsigned CNT_W        = $clog2(c_LONG_LIMIT + 1)
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  input  logic i_Clr_Press,
  input  logic i_Clr_Long,
  output logic o_Press_Pend,
  output logic o_Long_Pend,
  output logic o_Overrun
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(c_LONG_LIMIT);

  logic             sw_q, sw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             long_q, long_d;
  logic             ovr_q, ovr_d;
  logic             press_set_c, long_set_c;

  // A set that coincides with the arbiter's clear keeps the bit and is not a loss.
  always_comb begin
    sw_d        = i_Switch;
    cnt_d       = '0;
    press_set_c = i_Switch & ~sw_q;
    long_set_c  = i_Switch & (cnt_q == (LIMIT - CNT_W'(1)));
    if (i_Switch) begin
      cnt_d = (cnt_q == LIMIT) ? LIMIT : cnt_q + CNT_W'(1);
    end
    press_d = press_set_c | (press_q & ~i_Clr_Press);
    long_d  = long_set_c | (long_q & ~i_Clr_Long);
    ovr_d   = ovr_q
            | (press_set_c & press_q & ~i_Clr_Press)
            | (long_set_c & long_q & ~i_Clr_Long);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sw_q    <= i_Switch;
      cnt_q   <= '0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      long_q  <= long_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_Press_Pend = press_q;
  assign o_Long_Pend  = long_q;
  assign o_Overrun    = ovr_q;

endmodule

// File: rtl/switch_event_arbiter.sv
// Round-robin arbiter presenting press / long-press events from c_NUM_SW switch trackers.
module switch_event_arbiter
  import switch_event_arbiter_pkg::*;
#(
  parameter  int unsigned c_NUM_SW     = C_NUM_SW_DEF,
  parameter  int unsigned c_LONG_LIMIT = C_LONG_LIMIT_DEF,
  localparam int unsigned ID_W         = id_width(c_NUM_SW)
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [c_NUM_SW-1:0] i_Switch,
  output logic                o_Ev_Valid,
  input  logic                i_Ev_Ready,
  output logic [ID_W-1:0]     o_Ev_Id,
  output logic                o_Ev_Long,
  output logic                o_Overrun
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     ev_id_q, ev_id_d;
  logic                ev_long_q, ev_long_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic [c_NUM_SW-1:0] press_pend, long_pend, trk_ovr;
  logic [c_NUM_SW-1:0] clr_press_c, clr_long_c;
  logic [ID_W-1:0]     win_c;
  logic                any_pend_c;

  for (genvar g = 0; g < c_NUM_SW; g++) begin : g_trk
    switch_event_track #(.c_LONG_LIMIT(c_LONG_LIMIT)) u_trk (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Switch     (i_Switch[g]),
      .i_Clr_Press  (clr_press_c[g]),
      .i_Clr_Long   (clr_long_c[g]),
      .o_Press_Pend (press_pend[g]),
      .o_Long_Pend  (long_pend[g]),
      .o_Overrun    (trk_ovr[g])
    );
  end

  // First switch with anything pending, searching upward from rr_ptr with wrap.
  always_comb begin : arb_pick
    logic [ID_W:0] idx;
    logic          found;
    idx        = '0;
    found      = 1'b0;
    win_c      = '0;
    any_pend_c = |(press_pend | long_pend);
    for (int unsigned i = 0; i < c_NUM_SW; i++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
      if (idx >= (ID_W + 1)'(c_NUM_SW)) begin
        idx = idx - (ID_W + 1)'(c_NUM_SW);
      end
      if (!found && (press_pend[idx[ID_W-1:0]] || long_pend[idx[ID_W-1:0]])) begin
        found = 1'b1;
        win_c = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      ev_id_q   <= '0;
      ev_long_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ev_id_q   <= ev_id_d;
      ev_long_q <= ev_long_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (any_pend_c) state_d = ST_PRESENT;
      ST_PRESENT: if (i_Ev_Ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Event fields load only when leaving IDLE; press beats long within the winner.
  always_comb begin
    ev_id_d     = ev_id_q;
    ev_long_d   = ev_long_q;
    rr_ptr_d    = rr_ptr_q;
    clr_press_c = '0;
    clr_long_c  = '0;
    valid_d     = (state_d == ST_PRESENT);
    overrun_d   = overrun_q | (|trk_ovr);
    if (state_q == ST_IDLE && any_pend_c) begin
      ev_id_d            = win_c;
      ev_long_d          = ~press_pend[win_c];
      clr_press_c[win_c] = press_pend[win_c];
      clr_long_c[win_c]  = ~press_pend[win_c];
    end else if (state_q == ST_PRESENT && i_Ev_Ready) begin
      rr_ptr_d = (ev_id_q == ID_W'(c_NUM_SW - 1)) ? '0 : ev_id_q + ID_W'(1);
    end
  end

  assign o_Ev_Valid = valid_q;
  assign o_Ev_Id    = ev_id_q;
  assign o_Ev_Long  = ev_long_q;
  assign o_Overrun  = overrun_q;

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Randomized and directed bench for switch_event_arbiter against an event-level reference model.
module tb_switch_event_arbiter;

  localparam int N = 4;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b0000;
  logic       rdy = 1'b0;
  logic       ev_valid, ev_long, overrun;
  logic [1:0] ev_id;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  switch_event_arbiter #(.c_NUM_SW(N), .c_LONG_LIMIT(L)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Switch   (sw),
    .o_Ev_Valid (ev_valid),
    .i_Ev_Ready (rdy),
    .o_Ev_Id    (ev_id),
    .o_Ev_Long  (ev_long),
    .o_Overrun  (overrun)
  );

  // Reference model state: per-switch pending flags and hold lengths, one presented event.
  typedef struct {
    int id;
    bit lng;
  } ev_t;

  bit   m_prev [N];
  bit   m_pp   [N];
  bit   m_lp   [N];
  int   m_hold [N];
  bit   m_valid, m_long, m_ovr, m_lost;
  int   m_id, m_rr;
  ev_t  acc[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit clr_p [N];
    bit clr_l [N];
    bit lost_now;
    bit found;
    int c;
    lost_now = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      clr_p[i] = 1'b0;
      clr_l[i] = 1'b0;
    end
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = sw[i];
        m_pp[i]   = 1'b0;
        m_lp[i]   = 1'b0;
        m_hold[i] = 0;
      end
      m_valid = 1'b0; m_id = 0; m_long = 1'b0;
      m_ovr   = 1'b0; m_lost = 1'b0; m_rr = 0;
    end else begin
      if (m_valid) begin
        if (rdy) begin
          acc.push_back('{m_id, m_long});
          m_valid = 1'b0;
          m_rr    = (m_id + 1) % N;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!found && (m_pp[c] || m_lp[c])) begin
            found   = 1'b1;
            m_valid = 1'b1;
            m_id    = c;
            m_long  = !m_pp[c];
            if (m_pp[c]) clr_p[c] = 1'b1;
            else         clr_l[c] = 1'b1;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        bit ps, ls;
        ps = sw[i] && !m_prev[i];
        ls = sw[i] && (m_hold[i] == L - 1);
        if (ps && m_pp[i] && !clr_p[i]) lost_now = 1'b1;
        if (ls && m_lp[i] && !clr_l[i]) lost_now = 1'b1;
        m_pp[i]   = ps || (m_pp[i] && !clr_p[i]);
        m_lp[i]   = ls || (m_lp[i] && !clr_l[i]);
        m_hold[i] = sw[i] ? ((m_hold[i] < L) ? m_hold[i] + 1 : L) : 0;
        m_prev[i] = sw[i];
      end
      // A lost event shows on o_Overrun one cycle after it is recorded.
      m_ovr  = m_ovr || m_lost;
      m_lost = m_lost || lost_now;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("valid", int'(ev_valid), int'(m_valid));
    check_eq("id", int'(ev_id), m_id);
    check_eq("long", int'(ev_long), int'(m_long));
    check_eq("overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    acc.delete();
  endtask

  task automatic check_ev(input string tag, input int idx, input int id, input int lng);
    if (idx < acc.size()) begin
      check_eq({tag, "_id"}, acc[idx].id, id);
      check_eq({tag, "_long"}, int'(acc[idx].lng), lng);
    end else begin
      check_eq({tag, "_present"}, acc.size(), idx + 1);
    end
  endtask

  initial begin
    // Reset state
    run(2);
    check_eq("rst_valid", int'(ev_valid), 0);
    check_eq("rst_ovr", int'(overrun), 0);
    rst = 1'b0;

    // Single press
    do_reset();
    rdy = 1'b1; sw = 4'b0001;
    run(1);
    check_eq("single_lat1", int'(ev_valid), 0);
    run(1);
    check_eq("single_lat2", int'(ev_valid), 1);
    run(2); sw = 4'b0000; run(3);
    check_eq("single_n", acc.size(), 1);
    check_ev("single", 0, 0, 0);

    // Long press on switch 2
    do_reset();
    rdy = 1'b1; sw = 4'b0100;
    run(10); sw = 4'b0000; run(4);
    check_eq("long_n", acc.size(), 2);
    check_ev("long_a", 0, 2, 0);
    check_ev("long_b", 1, 2, 1);

    // Round-robin order from rr_ptr=0
    do_reset();
    rdy = 1'b0; sw = 4'b1011;
    run(2); sw = 4'b0000; run(3);
    rdy = 1'b1; run(8);
    check_eq("rr_n", acc.size(), 3);
    check_ev("rr_a", 0, 0, 0);
    check_ev("rr_b", 1, 1, 0);
    check_ev("rr_c", 2, 3, 0);

    // Backpressure with wrap from rr_ptr=3
    do_reset();
    rdy = 1'b1; sw = 4'b0100;
    run(3); sw = 4'b0000; run(2);
    rdy = 1'b0; sw = 4'b1001;
    run(2); sw = 4'b0000;
    run(5);
    check_eq("bp_hold_id", int'(ev_id), 3);
    rdy = 1'b1; run(6);
    check_eq("bp_n", acc.size(), 3);
    check_ev("bp_a", 1, 3, 0);
    check_ev("bp_b", 2, 0, 0);

    // Overrun: switch 1 re-pressed while its first press is still pending
    do_reset();
    rdy = 1'b0; sw = 4'b0001;
    run(3);
    sw = 4'b0011; run(1);
    sw = 4'b0001; run(1);
    sw = 4'b0011; run(1);
    sw = 4'b0000; run(3);
    check_eq("ovr_set", int'(overrun), 1);
    rdy = 1'b1; run(8);
    check_eq("ovr_sticky", int'(overrun), 1);
    check_eq("ovr_n", acc.size(), 2);
    check_ev("ovr_b", 1, 1, 0);

    // Reset while presenting, switch held through reset
    do_reset();
    rdy = 1'b0; sw = 4'b0100;
    run(3);
    check_eq("mid_valid_before", int'(ev_valid), 1);
    rst = 1'b1; run(1);
    check_eq("mid_valid_rst", int'(ev_valid), 0);
    check_eq("mid_id_rst", int'(ev_id), 0);
    rst = 1'b0; run(3);
    sw = 4'b0000; rdy = 1'b1; run(8);
    check_eq("mid_n", acc.size(), 0);

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) == 0) sw[b] = ~sw[b];
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
